i2c_target: RTL and testbench

- I2C target (responder) for the camera/VGA subsystem.
- Lets a bench master, or a second FPGA, load camera-style register writes into on-chip config registers and read them back: 16-bit register address, 8-bit data.
- Oversamples the open-drain SCL/SDA pins on the 25 MHz system clock and decodes START, STOP, address and data.
- Presents a simple register-file strobe interface; the register storage itself lives outside the block.

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_line_sync.sv | 45 ++++
 rtl/i2c_target.sv | 231 +++++++++++++++++++++++
 tb/tb_i2c_target.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding,
// default bus address, byte length and ACK levels.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REGH,
    REGH_ACK,
    REGL,
    REGL_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT_STOP
  } i2c_state_e;

  localparam logic [6:0] DEF_TARGET_ADDR = 7'h3C;
  localparam logic [3:0] BIT_CNT         = 4'd8;
  localparam logic       ACK_LVL         = 1'b0;
  localparam logic       NACK_LVL        = 1'b1;

  function automatic logic [7:0] shift_in(input logic [7:0] sr, input logic b);
    return {sr[6:0], b};
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer plus previous-value register on SCL/SDA; decodes
// SCL edges and START/STOP from the synchronized levels.
module i2c_line_sync (
  input  logic meg25,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  // [0] metastable stage, [1] synchronized level, [2] previous synchronized level
  logic [2:0] r_scl;
  logic [2:0] r_sda;
  logic       w_scl_s;
  logic       w_scl_p;
  logic       w_sda_s;
  logic       w_sda_p;

  // Reset to the idle-bus level so leaving reset never fakes a START
  always_ff @(posedge meg25) begin
    if (reset) begin
      r_scl <= 3'b111;
      r_sda <= 3'b111;
    end else begin
      r_scl <= {r_scl[1:0], scl_in};
      r_sda <= {r_sda[1:0], sda_in};
    end
  end

  assign w_scl_s = r_scl[1];
  assign w_scl_p = r_scl[2];
  assign w_sda_s = r_sda[1];
  assign w_sda_p = r_sda[2];

  assign scl_rise  =  w_scl_s & ~w_scl_p;
  assign scl_fall  = ~w_scl_s &  w_scl_p;
  assign start_det =  w_scl_s &  w_scl_p &  w_sda_p & ~w_sda_s;
  assign stop_det  =  w_scl_s &  w_scl_p & ~w_sda_p &  w_sda_s;
  assign sda_s     =  w_sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target with 16-bit register pointer and 8-bit data, exposing a
// register-file strobe interface (wr_en / rd_req) to external storage.
//
// state     | meaning
// IDLE      | bus free or after STOP
// ADDR      | shifting in target address + R/W
// ADDR_ACK  | driving ACK for our address
// REGH/REGL | shifting in pointer high / low byte
// *_ACK     | driving ACK for the byte just received
// WDATA     | shifting in a write data byte (burst)
// RDATA     | fetching and shifting out a read byte
// RDATA_ACK | sampling master ACK/NACK
// WAIT_STOP | not addressed or read ended; ignore until START/STOP
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = DEF_TARGET_ADDR,
  parameter int         ADDR_W      = 16
) (
  input  logic              meg25,
  input  logic              reset,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        wr_data,
  output logic              wr_en,
  output logic              rd_req,
  input  logic [7:0]        rd_data,
  output logic              busy
);

  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start_det;
  logic w_stop_det;
  logic w_sda_s;

  i2c_line_sync u_line_sync (
    .meg25     (meg25),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start_det),
    .stop_det  (w_stop_det),
    .sda_s     (w_sda_s)
  );

  i2c_state_e        r_state,    w_state_nxt;
  logic [3:0]        r_bit_cnt,  w_cnt_nxt;
  logic [7:0]        r_shift,    w_shift_nxt;
  logic              r_rw,       w_rw_nxt;
  logic [7:0]        r_tx,       w_tx_nxt;
  logic              r_sda_oe,   w_oe_nxt;
  logic [ADDR_W-1:0] r_reg_addr, w_addr_nxt;
  logic [7:0]        r_wr_data,  w_wdata_nxt;
  logic              r_wr_en,    w_wr_en_nxt;
  logic              r_rd_req,   w_rd_req_nxt;
  logic              r_busy,     w_busy_nxt;
  logic              r_rd_lat;
  logic [7:0]        w_byte;
  logic              w_last_bit;

  assign w_byte     = shift_in(r_shift, w_sda_s);
  assign w_last_bit = (r_bit_cnt == BIT_CNT - 4'd1);

  always_ff @(posedge meg25) begin
    if (reset) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_rw       <= 1'b0;
      r_tx       <= '0;
      r_sda_oe   <= 1'b0;
      r_reg_addr <= '0;
      r_wr_data  <= '0;
      r_wr_en    <= 1'b0;
      r_rd_req   <= 1'b0;
      r_rd_lat   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_rw       <= w_rw_nxt;
      r_tx       <= w_tx_nxt;
      r_sda_oe   <= w_oe_nxt;
      r_reg_addr <= w_addr_nxt;
      r_wr_data  <= w_wdata_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_rd_req   <= w_rd_req_nxt;
      r_rd_lat   <= r_rd_req;
      r_busy     <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_bit_cnt;
    w_shift_nxt  = r_shift;
    w_rw_nxt     = r_rw;
    w_tx_nxt     = r_tx;
    w_oe_nxt     = r_sda_oe;
    w_addr_nxt   = r_reg_addr;
    w_wdata_nxt  = r_wr_data;
    w_wr_en_nxt  = 1'b0;
    w_rd_req_nxt = 1'b0;
    w_busy_nxt   = r_busy;

    // Read byte arrives the cycle after rd_req, long before the next SCL fall
    if (r_rd_lat) w_tx_nxt = rd_data;

    if (w_stop_det) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_oe_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
    end else if (w_start_det) begin
      w_state_nxt = ADDR;
      w_cnt_nxt   = '0;
      w_oe_nxt    = 1'b0;
    end else begin
      case (r_state)
        IDLE, WAIT_STOP: w_oe_nxt = 1'b0;

        ADDR: if (w_scl_rise) begin
          w_shift_nxt = w_byte;
          w_cnt_nxt   = r_bit_cnt + 4'd1;
          if (w_last_bit) begin
            w_cnt_nxt = '0;
            w_rw_nxt  = w_sda_s;
            if (w_byte[7:1] == TARGET_ADDR) begin
              w_state_nxt = ADDR_ACK;
              w_busy_nxt  = 1'b1;
            end else begin
              w_state_nxt = WAIT_STOP;
            end
          end
        end

        // A read hands over at the 9th rise so the fetch completes before
        // the falling edge that must present bit 7; ACK is held until then.
        ADDR_ACK: begin
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_oe_nxt = 1'b1;
            end else if (!r_rw) begin
              w_oe_nxt    = 1'b0;
              w_state_nxt = REGH;
            end
          end else if (w_scl_rise && r_sda_oe && r_rw) begin
            w_state_nxt  = RDATA;
            w_rd_req_nxt = 1'b1;
            w_cnt_nxt    = '0;
          end
        end

        REGH, REGL, WDATA: if (w_scl_rise) begin
          w_shift_nxt = w_byte;
          w_cnt_nxt   = r_bit_cnt + 4'd1;
          if (w_last_bit) begin
            w_cnt_nxt = '0;
            if (r_state == REGH) begin
              w_addr_nxt[ADDR_W-1 -: 8] = w_byte;
              w_state_nxt               = REGH_ACK;
            end else if (r_state == REGL) begin
              w_addr_nxt[7:0] = w_byte;
              w_state_nxt     = REGL_ACK;
            end else begin
              w_wdata_nxt = w_byte;
              w_wr_en_nxt = 1'b1;
              w_state_nxt = WDATA_ACK;
            end
          end
        end

        REGH_ACK, REGL_ACK, WDATA_ACK: if (w_scl_fall) begin
          if (!r_sda_oe) begin
            w_oe_nxt = 1'b1;
          end else begin
            w_oe_nxt = 1'b0;
            if (r_state == REGH_ACK) begin
              w_state_nxt = REGL;
            end else begin
              w_state_nxt = WDATA;
              if (r_state == WDATA_ACK) w_addr_nxt = r_reg_addr + ADDR_W'(1);
            end
          end
        end

        RDATA: if (w_scl_fall) begin
          if (r_bit_cnt == BIT_CNT) begin
            w_oe_nxt    = 1'b0;
            w_state_nxt = RDATA_ACK;
            w_cnt_nxt   = '0;
          end else begin
            w_oe_nxt  = ~r_tx[7];
            w_tx_nxt  = {r_tx[6:0], 1'b0};
            w_cnt_nxt = r_bit_cnt + 4'd1;
          end
        end

        RDATA_ACK: if (w_scl_rise) begin
          if (w_sda_s == ACK_LVL) begin
            w_addr_nxt   = r_reg_addr + ADDR_W'(1);
            w_state_nxt  = RDATA;
            w_rd_req_nxt = 1'b1;
            w_cnt_nxt    = '0;
          end else begin
            w_state_nxt = WAIT_STOP;
          end
        end

        default: begin
          w_state_nxt = IDLE;
          w_oe_nxt    = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe   = r_sda_oe;
  assign reg_addr = r_reg_addr;
  assign wr_data  = r_wr_data;
  assign wr_en    = r_wr_en;
  assign rd_req   = r_rd_req;
  assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C master on an open-drain SDA model,
// with a scoreboard of expected write/read strobes.
module tb_i2c_target;
  import i2c_pkg::*;

  logic        meg25 = 1'b0;
  logic        reset = 1'b1;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic [7:0]  rd_data = 8'h00;
  logic        scl_in;
  logic        sda_in;
  logic        sda_oe;
  logic [15:0] reg_addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        rd_req;
  logic        busy;

  assign scl_in = m_scl;
  assign sda_in = m_sda & ~sda_oe;

  i2c_target dut (
    .meg25    (meg25),
    .reset    (reset),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda_oe   (sda_oe),
    .reg_addr (reg_addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  always #20 meg25 = ~meg25;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_exp_t;

  wr_exp_t     wr_q[$];
  logic [15:0] rd_addr_q[$];
  logic [7:0]  rd_val_q[$];
  wr_exp_t     e_wr;
  logic [15:0] e_rd;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  wr_cnt   = 0;
  int  rd_cnt   = 0;
  int  oe_seen  = 0;
  int  busy_seen = 0;
  time tq = 2500;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge meg25) begin
    if (!reset) begin
      if (wr_en) begin
        wr_cnt++;
        if (wr_q.size() == 0) begin
          check_eq("wr_unexpected", 32'd1, 32'd0);
        end else begin
          e_wr = wr_q.pop_front();
          check_eq("wr_addr", 32'(reg_addr), 32'(e_wr.addr));
          check_eq("wr_data", 32'(wr_data), 32'(e_wr.data));
        end
      end
      if (rd_req) begin
        rd_cnt++;
        if (rd_addr_q.size() == 0) begin
          check_eq("rd_unexpected", 32'd1, 32'd0);
        end else begin
          e_rd = rd_addr_q.pop_front();
          check_eq("rd_addr", 32'(reg_addr), 32'(e_rd));
        end
        rd_data = (rd_val_q.size() != 0) ? rd_val_q.pop_front() : 8'hEE;
      end
      if (sda_oe) oe_seen++;
      if (busy)   busy_seen++;
    end
  end

  task automatic i2c_start();
    m_sda = 1'b1; #tq;
    m_scl = 1'b1; #tq;
    m_sda = 1'b0; #tq;
    m_scl = 1'b0; #tq;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #tq;
    m_scl = 1'b1; #tq;
    m_sda = 1'b1; #(2*tq);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      m_sda = b[i]; #tq;
      m_scl = 1'b1; #(2*tq);
      m_scl = 1'b0; #tq;
    end
  endtask

  task automatic ack_slot(output logic ack);
    m_sda = 1'b1; #tq;
    m_scl = 1'b1; #tq;
    ack = sda_in; #tq;
    m_scl = 1'b0; #tq;
  endtask

  task automatic write_byte(input logic [7:0] b, input string tag, input logic exp_ack);
    logic a;
    send_bits(b, 8);
    ack_slot(a);
    check_eq(tag, 32'(a), 32'(exp_ack));
  endtask

  task automatic read_byte(output logic [7:0] b, input logic mack);
    for (int i = 7; i >= 0; i--) begin
      m_sda = 1'b1; #tq;
      m_scl = 1'b1; #tq;
      b[i] = sda_in; #tq;
      m_scl = 1'b0; #tq;
    end
    m_sda = mack; #tq;
    m_scl = 1'b1; #(2*tq);
    m_scl = 1'b0; #tq;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    int w0;
    int r0;

    repeat (5) @(posedge meg25);
    #1;
    check_eq("rst_sda_oe",   32'(sda_oe),        32'd0);
    check_eq("rst_reg_addr", 32'(reg_addr),      32'd0);
    check_eq("rst_wr_data",  32'(wr_data),       32'd0);
    check_eq("rst_wr_en",    32'(wr_en),         32'd0);
    check_eq("rst_rd_req",   32'(rd_req),        32'd0);
    check_eq("rst_busy",     32'(busy),          32'd0);
    check_eq("rst_state",    32'(dut.r_state),   32'(IDLE));
    check_eq("rst_bit_cnt",  32'(dut.r_bit_cnt), 32'd0);
    @(negedge meg25);
    reset = 1'b0;
    repeat (5) @(negedge meg25);

    // Single write at 100 kHz
    tq = 2500;
    w0 = wr_cnt;
    wr_q.push_back('{addr: 16'h3008, data: 8'h82});
    i2c_start();
    write_byte(8'h78, "t1_ack_addr", ACK_LVL);
    write_byte(8'h30, "t1_ack_regh", ACK_LVL);
    write_byte(8'h08, "t1_ack_regl", ACK_LVL);
    write_byte(8'h82, "t1_ack_data", ACK_LVL);
    check_eq("t1_busy_before_stop", 32'(busy), 32'd1);
    i2c_stop();
    check_eq("t1_busy_after_stop", 32'(busy), 32'd0);
    check_eq("t1_wr_count", 32'(wr_cnt - w0), 32'd1);

    // Address mismatch, ~390 kHz from here on
    tq = 640;
    w0 = wr_cnt;
    oe_seen = 0;
    busy_seen = 0;
    i2c_start();
    write_byte(8'h84, "t2_nack_addr", NACK_LVL);
    write_byte(8'h30, "t2_nack_b1", NACK_LVL);
    write_byte(8'h08, "t2_nack_b2", NACK_LVL);
    write_byte(8'h82, "t2_nack_b3", NACK_LVL);
    i2c_stop();
    check_eq("t2_oe_seen",   32'(oe_seen),     32'd0);
    check_eq("t2_busy_seen", 32'(busy_seen),   32'd0);
    check_eq("t2_wr_count",  32'(wr_cnt - w0), 32'd0);

    // Burst write across the pointer wrap
    w0 = wr_cnt;
    wr_q.push_back('{addr: 16'hFFFF, data: 8'h11});
    wr_q.push_back('{addr: 16'h0000, data: 8'h22});
    wr_q.push_back('{addr: 16'h0001, data: 8'h33});
    i2c_start();
    write_byte(8'h78, "t3_ack_addr", ACK_LVL);
    write_byte(8'hFF, "t3_ack_regh", ACK_LVL);
    write_byte(8'hFF, "t3_ack_regl", ACK_LVL);
    write_byte(8'h11, "t3_ack_d0", ACK_LVL);
    write_byte(8'h22, "t3_ack_d1", ACK_LVL);
    write_byte(8'h33, "t3_ack_d2", ACK_LVL);
    i2c_stop();
    check_eq("t3_wr_count",   32'(wr_cnt - w0),  32'd3);
    check_eq("t3_reg_addr",   32'(reg_addr),     32'h0002);
    check_eq("t3_wr_q_empty", 32'(wr_q.size()),  32'd0);

    // Pointer write, repeated START, two-byte read
    w0 = wr_cnt;
    r0 = rd_cnt;
    rd_addr_q.push_back(16'h300A);
    rd_addr_q.push_back(16'h300B);
    rd_val_q.push_back(8'h56);
    rd_val_q.push_back(8'hA5);
    i2c_start();
    write_byte(8'h78, "t4_ack_waddr", ACK_LVL);
    write_byte(8'h30, "t4_ack_regh", ACK_LVL);
    write_byte(8'h0A, "t4_ack_regl", ACK_LVL);
    i2c_start();
    write_byte(8'h79, "t4_ack_raddr", ACK_LVL);
    read_byte(rb, ACK_LVL);
    check_eq("t4_rd_byte0", 32'(rb), 32'h56);
    read_byte(rb, NACK_LVL);
    check_eq("t4_rd_byte1", 32'(rb), 32'hA5);
    check_eq("t4_oe_after_nack", 32'(sda_oe), 32'd0);
    i2c_stop();
    check_eq("t4_state_idle", 32'(dut.r_state), 32'(IDLE));
    check_eq("t4_rd_count",   32'(rd_cnt - r0), 32'd2);
    check_eq("t4_wr_count",   32'(wr_cnt - w0), 32'd0);
    check_eq("t4_reg_addr",   32'(reg_addr),    32'h300B);

    // STOP after half a data byte
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'h78, "t5_ack_addr", ACK_LVL);
    write_byte(8'h12, "t5_ack_regh", ACK_LVL);
    write_byte(8'h34, "t5_ack_regl", ACK_LVL);
    send_bits(8'hA0, 4);
    i2c_stop();
    check_eq("t5_wr_count", 32'(wr_cnt - w0), 32'd0);
    check_eq("t5_reg_addr", 32'(reg_addr),    32'h1234);

    // Reset while the target is driving the address ACK
    i2c_start();
    send_bits(8'h78, 8);
    m_sda = 1'b1;
    #tq;
    check_eq("t6_oe_in_ack", 32'(sda_oe), 32'd1);
    @(negedge meg25);
    reset = 1'b1;
    @(posedge meg25);
    #1;
    check_eq("t6_oe_after_rst",    32'(sda_oe),      32'd0);
    check_eq("t6_state_after_rst", 32'(dut.r_state), 32'(IDLE));
    @(negedge meg25);
    reset = 1'b0;
    i2c_stop();
    check_eq("t6_busy_end", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
